sdram_port_responder: RTL and testbench

Responder end of the core-to-SDRAM word interface used by the processing cores (read/write, 23-bit address, 32-bit data, one-cycle `finished` pulse). It serves two client cores through a round-robin arbiter. It turns each granted request into a single Avalon-MM master transaction toward the SDRAM controller. It returns read data and completion to the originating client only.

---
 rtl/sdram_port_responder.sv | 182 ++++++++++++++++++
 tb/tb_sdram_port_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_responder.sv
// Two-client responder for the core-to-SDRAM word interface: round-robin
// arbitration, one Avalon-MM transaction at a time, completion routed back to the requester.

module sdram_port_client #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              done,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] readdata,
    output logic              finished
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            readdata <= '0;
            finished <= 1'b0;
        end else begin
            finished <= done;
            if (load)
                readdata <= rdata;
        end
    end
endmodule

module sdram_port_responder #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_writedata,
    output logic [DATA_W-1:0] c0_readdata,
    output logic              c0_finished,
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_writedata,
    output logic [DATA_W-1:0] c1_readdata,
    output logic              c1_finished,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);
    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t state, state_nxt;

    logic [NUM_CLIENTS-1:0]             rd_req, wr_req, req;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_in;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] wdata_in;
    logic [NUM_CLIENTS-1:0][DATA_W-1:0] rdata_out;
    logic [NUM_CLIENTS-1:0]             fin_out;
    logic [NUM_CLIENTS-1:0]             fin_set, rd_load;

    logic              gnt, gnt_nxt;
    logic              op_wr, op_wr_nxt;
    logic              last_grant, last_grant_nxt;
    logic              pick;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              rd_nxt, wr_nxt;

    assign rd_req   = {c1_read, c0_read};
    assign wr_req   = {c1_write, c0_write};
    assign req      = rd_req | wr_req;
    assign addr_in  = {c1_addr, c0_addr};
    assign wdata_in = {c1_writedata, c0_writedata};

    assign c0_readdata    = rdata_out[0];
    assign c1_readdata    = rdata_out[1];
    assign c0_finished    = fin_out[0];
    assign c1_finished    = fin_out[1];
    assign avm_byteenable = 4'hF;

    // On contention the client not served last wins; otherwise whoever asks.
    always_comb begin
        if (req[0] && req[1])
            pick = ~last_grant;
        else
            pick = req[1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            op_wr         <= 1'b0;
            last_grant    <= 1'b1;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
        end else begin
            state         <= state_nxt;
            gnt           <= gnt_nxt;
            op_wr         <= op_wr_nxt;
            last_grant    <= last_grant_nxt;
            avm_address   <= addr_nxt;
            avm_writedata <= wdata_nxt;
            avm_read      <= rd_nxt;
            avm_write     <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        op_wr_nxt      = op_wr;
        last_grant_nxt = last_grant;
        addr_nxt       = avm_address;
        wdata_nxt      = avm_writedata;
        rd_nxt         = avm_read;
        wr_nxt         = avm_write;
        fin_set        = '0;
        rd_load        = '0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    // A simultaneous read and write on one client is treated as a write.
                    gnt_nxt        = pick;
                    op_wr_nxt      = wr_req[pick];
                    last_grant_nxt = pick;
                    addr_nxt       = addr_in[pick];
                    wdata_nxt      = wdata_in[pick];
                    wr_nxt         = wr_req[pick];
                    rd_nxt         = ~wr_req[pick];
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    rd_nxt = 1'b0;
                    wr_nxt = 1'b0;
                    if (op_wr) begin
                        fin_set[gnt] = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        state_nxt = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (avm_readdatavalid) begin
                    rd_load[gnt] = 1'b1;
                    fin_set[gnt] = 1'b1;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        sdram_port_client #(.DATA_W(DATA_W)) u_client (
            .clk      (i_clk),
            .rst      (i_rst),
            .load     (rd_load[i]),
            .done     (fin_set[i]),
            .rdata    (avm_readdata),
            .readdata (rdata_out[i]),
            .finished (fin_out[i])
        );
    end
endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed bench for sdram_port_responder: write, stalled read, contention,
// reset during a read, stray readdatavalid and read+write collision.

module tb_sdram_port_responder;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        c0_read, c0_write, c1_read, c1_write;
    logic [22:0] c0_addr, c1_addr;
    logic [31:0] c0_writedata, c1_writedata;
    logic [31:0] c0_readdata, c1_readdata;
    logic        c0_finished, c1_finished;
    logic [22:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest, avm_readdatavalid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    sdram_port_responder dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .c0_read(c0_read), .c0_write(c0_write), .c0_addr(c0_addr),
        .c0_writedata(c0_writedata), .c0_readdata(c0_readdata), .c0_finished(c0_finished),
        .c1_read(c1_read), .c1_write(c1_write), .c1_addr(c1_addr),
        .c1_writedata(c1_writedata), .c1_readdata(c1_readdata), .c1_finished(c1_finished),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    // Advance one clock; inputs are driven and outputs observed 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
        c0_addr = '0; c1_addr = '0; c0_writedata = '0; c1_writedata = '0;
        avm_readdata = '0; avm_waitrequest = 0; avm_readdatavalid = 0;
        step(); step();
        i_rst = 1'b1;
        n_cmp++;
        if ({avm_read, avm_write, avm_address, avm_writedata} !== 57'd0) begin
            n_err++; $display("FAIL reset_avm got rd=%b wr=%b a=%h d=%h exp zeros",
                              avm_read, avm_write, avm_address, avm_writedata);
        end
        n_cmp++;
        if ({c0_finished, c1_finished, c0_readdata, c1_readdata} !== 66'd0) begin
            n_err++; $display("FAIL reset_clients got f=%b%b rd0=%h rd1=%h exp zeros",
                              c1_finished, c0_finished, c0_readdata, c1_readdata);
        end
        n_cmp++;
        if (avm_byteenable !== 4'hF) begin
            n_err++; $display("FAIL byteenable got %h exp f", avm_byteenable);
        end
    endtask

    task automatic test_write();
        c0_write = 1; c0_addr = 23'h000010; c0_writedata = 32'hDEADBEEF;
        step();
        n_cmp++;
        if ({avm_write, avm_read, avm_address, avm_writedata} !== {2'b10, 23'h000010, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_issue got wr=%b rd=%b a=%h d=%h exp wr=1 rd=0 a=000010 d=deadbeef",
                              avm_write, avm_read, avm_address, avm_writedata);
        end
        n_cmp++;
        if ({c1_finished, c0_finished} !== 2'b00) begin
            n_err++; $display("FAIL wr_early_fin got %b%b exp 00", c1_finished, c0_finished);
        end
        step();
        n_cmp++;
        if ({c1_finished, c0_finished, avm_write} !== 3'b010) begin
            n_err++; $display("FAIL wr_done got f1=%b f0=%b wr=%b exp f1=0 f0=1 wr=0",
                              c1_finished, c0_finished, avm_write);
        end
        c0_write = 0;
        step();
        n_cmp++;
        if ({c1_finished, c0_finished} !== 2'b00) begin
            n_err++; $display("FAIL wr_fin_len got %b%b exp 00", c1_finished, c0_finished);
        end
    endtask

    task automatic test_read_stall();
        c1_read = 1; c1_addr = 23'h7FFFFF; avm_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) avm_waitrequest = 0;
            n_cmp++;
            if ({avm_read, avm_write, avm_address} !== {2'b10, 23'h7FFFFF}) begin
                n_err++; $display("FAIL rd_hold%0d got rd=%b wr=%b a=%h exp rd=1 wr=0 a=7fffff",
                                  i, avm_read, avm_write, avm_address);
            end
        end
        step();
        n_cmp++;
        if (avm_read !== 1'b0) begin
            n_err++; $display("FAIL rd_drop got %b exp 0", avm_read);
        end
        step(); step();
        avm_readdatavalid = 1; avm_readdata = 32'h12345678;
        n_cmp++;
        if (c1_finished !== 1'b0) begin
            n_err++; $display("FAIL rd_early_fin got %b exp 0", c1_finished);
        end
        step();
        avm_readdatavalid = 0; avm_readdata = 32'h0;
        n_cmp++;
        if ({c1_finished, c0_finished, c1_readdata, c0_readdata} !== {2'b10, 32'h12345678, 32'h0}) begin
            n_err++; $display("FAIL rd_done got f1=%b f0=%b rd1=%h rd0=%h exp 1 0 12345678 0",
                              c1_finished, c0_finished, c1_readdata, c0_readdata);
        end
        c1_read = 0;
        step();
        c1_write = 1; c1_writedata = 32'h0BADF00D;
        step(); step();
        n_cmp++;
        if ({c1_finished, c1_readdata} !== {1'b1, 32'h12345678}) begin
            n_err++; $display("FAIL rd_keep got f1=%b rd1=%h exp 1 12345678", c1_finished, c1_readdata);
        end
        c1_write = 0;
        step();
    endtask

    task automatic test_contention();
        int n;
        logic g;
        c0_addr = 23'h000100; c1_addr = 23'h000200;
        c0_read = 1; c1_read = 1;
        for (int t = 0; t < 4; t++) begin
            g = t[0];
            n = 0;
            while (!avm_read && n < 8) begin step(); n++; end
            n_cmp++;
            if (avm_address !== (g ? 23'h000200 : 23'h000100)) begin
                n_err++; $display("FAIL arb_order%0d got a=%h (wait %0d) exp client %0d", t, avm_address, n, g);
            end
            step();
            avm_readdatavalid = 1; avm_readdata = 32'hC0000000 + t;
            step();
            avm_readdatavalid = 0;
            n_cmp++;
            if ({c1_finished, c0_finished} !== (g ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL arb_fin%0d got %b%b exp client %0d", t, c1_finished, c0_finished, g);
            end
            n_cmp++;
            if ((g ? c1_readdata : c0_readdata) !== 32'hC0000000 + t) begin
                n_err++; $display("FAIL arb_data%0d got %h exp %h", t, g ? c1_readdata : c0_readdata,
                                  32'hC0000000 + t);
            end
            step();
            n_cmp++;
            if ({c1_finished, c0_finished, avm_read} !== 3'b000) begin
                n_err++; $display("FAIL arb_idle%0d got f=%b%b rd=%b exp 000",
                                  t, c1_finished, c0_finished, avm_read);
            end
        end
        c0_read = 0; c1_read = 0;
        step(); step(); step();
    endtask

    task automatic test_reset_mid_read();
        c0_read = 1; c0_addr = 23'h000005;
        step();
        c0_read = 0;
        step();
        i_rst = 0;
        step();
        i_rst = 1; avm_readdatavalid = 1; avm_readdata = 32'hAAAA5555;
        step();
        avm_readdatavalid = 0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({c1_finished, c0_finished, c0_readdata, c1_readdata} !== 66'd0) begin
                n_err++; $display("FAIL rst_abandon%0d got f=%b%b rd0=%h rd1=%h exp zeros",
                                  i, c1_finished, c0_finished, c0_readdata, c1_readdata);
            end
            step();
        end
        c0_write = 1; c0_addr = 23'h000111; c0_writedata = 32'h1;
        c1_write = 1; c1_addr = 23'h000222; c1_writedata = 32'h2;
        step();
        n_cmp++;
        if ({avm_write, avm_address} !== {1'b1, 23'h000111}) begin
            n_err++; $display("FAIL rst_first_gnt got wr=%b a=%h exp 1 000111", avm_write, avm_address);
        end
        step();
        c0_write = 0;
        step(); step();
        n_cmp++;
        if ({avm_write, avm_address, avm_writedata} !== {1'b1, 23'h000222, 32'h2}) begin
            n_err++; $display("FAIL rst_second_gnt got wr=%b a=%h d=%h exp 1 000222 2",
                              avm_write, avm_address, avm_writedata);
        end
        step();
        c1_write = 0;
        n_cmp++;
        if ({c1_finished, c0_finished} !== 2'b10) begin
            n_err++; $display("FAIL rst_second_fin got %b%b exp 10", c1_finished, c0_finished);
        end
        step();
    endtask

    task automatic test_stray_valid();
        avm_readdatavalid = 1; avm_readdata = 32'hFFFFFFFF;
        step(); step();
        n_cmp++;
        if ({c1_finished, c0_finished, avm_read, avm_write, c0_readdata, c1_readdata} !== 68'd0) begin
            n_err++; $display("FAIL stray_idle got f=%b%b rd=%b wr=%b rd0=%h rd1=%h exp zeros",
                              c1_finished, c0_finished, avm_read, avm_write, c0_readdata, c1_readdata);
        end
        c0_write = 1; c0_addr = 23'h000044; c0_writedata = 32'h44;
        step();
        step();
        c0_write = 0;
        n_cmp++;
        if ({c0_finished, c0_readdata, c1_readdata} !== {1'b1, 64'd0}) begin
            n_err++; $display("FAIL stray_write got f0=%b rd0=%h rd1=%h exp 1 0 0",
                              c0_finished, c0_readdata, c1_readdata);
        end
        avm_readdatavalid = 0;
        step();
    endtask

    task automatic test_rd_wr_both();
        c0_read = 1; c0_write = 1; c0_addr = 23'h000033; c0_writedata = 32'h55;
        avm_readdata = 32'h99999999;
        step();
        n_cmp++;
        if ({avm_write, avm_read, avm_writedata} !== {2'b10, 32'h55}) begin
            n_err++; $display("FAIL both_op got wr=%b rd=%b d=%h exp 1 0 55", avm_write, avm_read, avm_writedata);
        end
        avm_readdatavalid = 1;
        step();
        avm_readdatavalid = 0;
        c0_read = 0; c0_write = 0;
        n_cmp++;
        if ({c0_finished, c0_readdata} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL both_done got f0=%b rd0=%h exp 1 0", c0_finished, c0_readdata);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_contention();
        test_reset_mid_read();
        test_stray_valid();
        test_rd_wr_both();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
